dbf_sum_tree: RTL and testbench
===============================

Name: dbf_sum_tree

Overview:
- Downstream stage of the per-channel DBF blocks (coarse delay, fine delay, apodisation).
- Consumes the NUM_CH apodised channel outputs, each 32-bit signed with its own valid bit, and forms the delay-and-sum beamformed sample.
- Implementation is a registered binary adder tree with saturation, plus a per-line sample counter and line-done pulse.
- Output feeds the envelope/decimation chain.

Parameters:
- NUM_CH, 16, number of channels summed; power of two, 2..32.
- CH_WD, 32, width of each signed channel input.
- OUT_WD, 32, width of the signed beamformed output after saturation.
- CNT_WD, 14, width of the sample counter and line length.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- start  in  1  receive window enable, shared with the channel blocks.
- tx_en  in  1  transmit active; forces bubbles.
- ch_din  in  NUM_CH*CH_WD  packed channel samples; channel k occupies bits [k*CH_WD +: CH_WD], signed.
- ch_din_valid  in  NUM_CH  per-channel valid bits.
- line_len  in  CNT_WD  samples per receive line; sampled while start=0.
- bf_dout  out  OUT_WD  signed beamformed sample.
- bf_dout_valid  out  1  bf_dout qualifier.
- sample_cnt  out  CNT_WD  index of the current bf_dout within the line.
- line_done  out  1  one-cycle pulse, coincident with the last sample of a line.
- valid_err  out  1  sticky channel misalignment flag.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low: the ports are clk and rst_n, and every register clears on negedge rst_n.
  - Reset values: bf_dout=0, bf_dout_valid=0, sample_cnt=0, line_done=0, valid_err=0. All pipeline data and valid registers are 0.
- Acceptance:
  - in_ok = start & ~tx_en & (&ch_din_valid).
  - Only in_ok cycles inject a valid token. Any other cycle injects a bubble, and the bubble's data is don't-care.
- Misalignment:
  - If start=1, tx_en=0 and ch_din_valid is neither all-0 nor all-1, then valid_err sets to 1 on the next edge and that cycle is a bubble.
  - valid_err holds until start=0, which clears it on the next edge.
- Tree:
  - log2(NUM_CH) registered adder levels. Each level widens by 1 bit; level L output width is CH_WD+L. Adds are sign-extended.
  - For NUM_CH=16, the final sum is 36 bits.
  - A valid bit travels alongside the data at each level.
- Output register:
  - Saturates the full-width sum to OUT_WD: values above 2^(OUT_WD-1)-1 clamp to the max, values below -2^(OUT_WD-1) clamp to the min. No rounding.
- Latency: log2(NUM_CH)+1 cycles from the in_ok edge to bf_dout_valid (5 for the defaults). Throughput is one sample per clock, with no back-pressure.
- Counter:
  - Increments on each bf_dout_valid and is presented with the sample.
  - line_done=1 when bf_dout_valid & (sample_cnt == line_len_q-1). The counter then wraps to 0.
  - line_len_q is the value latched on the rising edge of start.
  - line_len_q=0: line_done never asserts and the counter wraps at 2^CNT_WD.
- start falling: synchronously clears all pipeline valid bits, bf_dout_valid and sample_cnt on the next edge. In-flight samples are discarded. Data registers hold their values.
- tx_en=1 while start=1: bubbles only. Tokens already in flight complete normally.
- Simultaneous in_ok and valid_err conditions cannot occur; they are mutually exclusive by definition.
- Reset mid-line: everything clears immediately. The next line begins after start re-rises.

Decomposition:
- Package dbf_sum_pkg holds the defaults (NUM_CH, CH_WD, OUT_WD, CNT_WD), the TREE_LVLS=log2(NUM_CH) constant and the sat_min/sat_max constants.
- Sub-module dbf_add_level: one registered level. It takes N signed operands of width W and produces N/2 sums of width W+1 with a valid bit and a synchronous flush input. The top level generates it log2(NUM_CH) times.

Test Plan:
- Reset with all inputs at max: outputs stay 0 during rst_n=0 and for 5 cycles after release.
- start=1, all valid, every channel=1000 for 4 cycles, line_len=4: bf_dout=16000 on cycles 5-8, sample_cnt=0,1,2,3, line_done only with sample 3.
- All channels=0x7FFFFFFF: bf_dout=0x7FFFFFFF. All channels=0x80000000: bf_dout=0x80000000. Channels alternating +5/-3: bf_dout=16.
- ch_din_valid=0x00FF for one cycle mid-stream: valid_err=1, that slot yields no output and neighbouring samples are correct; start=0 clears valid_err.
- start falls 2 cycles after 3 accepted samples: no bf_dout_valid appears afterwards and sample_cnt=0.
- tx_en=1 for 2 cycles within a valid stream: two-cycle gap in bf_dout_valid, with the counter continuing without skipped indices.

Source files
------------

// File: rtl/dbf_sum_pkg.sv
// Shared defaults for the delay-and-sum adder tree: geometry, widths and
// saturation limits of the beamformed output.
package dbf_sum_pkg;

  localparam int unsigned NUM_CH    = 16;
  localparam int unsigned CH_WD     = 32;
  localparam int unsigned OUT_WD    = 32;
  localparam int unsigned CNT_WD    = 14;
  localparam int unsigned TREE_LVLS = $clog2(NUM_CH);

  localparam logic [OUT_WD-1:0] SAT_MAX = {1'b0, {(OUT_WD-1){1'b1}}};
  localparam logic [OUT_WD-1:0] SAT_MIN = {1'b1, {(OUT_WD-1){1'b0}}};

endpackage

// File: rtl/dbf_add_level.sv
// One registered adder-tree level: N signed W-bit operands summed pairwise
// into N/2 sign-extended (W+1)-bit results, with a travelling valid bit.
module dbf_add_level #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [N*W-1:0]         din,
  output logic [(N/2)*(W+1)-1:0] dout,
  output logic                   dout_valid
);

  logic [(N/2)*(W+1)-1:0] sum_c;

  // Pairwise sign-extended adds
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N / 2); i++) begin
      sum_c[i*(W+1) +: (W+1)] = (W+1)'($signed(din[(2*i)*W +: W]))
                              + (W+1)'($signed(din[(2*i+1)*W +: W]));
    end
  end

  // Flush drops the token but leaves the data register untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= in_valid;
      if (in_valid) dout <= sum_c;
    end
  end

endmodule

// File: rtl/dbf_sum_tree.sv
// Delay-and-sum beamformer output stage: registered adder tree over all
// apodised channels, output saturation, per-line sample counter.
module dbf_sum_tree #(
  parameter int unsigned NUM_CH = dbf_sum_pkg::NUM_CH,
  parameter int unsigned CH_WD  = dbf_sum_pkg::CH_WD,
  parameter int unsigned OUT_WD = dbf_sum_pkg::OUT_WD,
  parameter int unsigned CNT_WD = dbf_sum_pkg::CNT_WD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    tx_en,
  input  logic [NUM_CH*CH_WD-1:0] ch_din,
  input  logic [NUM_CH-1:0]       ch_din_valid,
  input  logic [CNT_WD-1:0]       line_len,
  output logic [OUT_WD-1:0]       bf_dout,
  output logic                    bf_dout_valid,
  output logic [CNT_WD-1:0]       sample_cnt,
  output logic                    line_done,
  output logic                    valid_err
);

  localparam int unsigned TREE_LVLS = $clog2(NUM_CH);
  localparam int unsigned SUM_WD    = CH_WD + TREE_LVLS;
  localparam int unsigned EXT_WD    = SUM_WD - OUT_WD + 1;
  localparam logic [OUT_WD-1:0] SAT_HI = {1'b0, {(OUT_WD-1){1'b1}}};
  localparam logic [OUT_WD-1:0] SAT_LO = {1'b1, {(OUT_WD-1){1'b0}}};

  logic              in_ok_c;
  logic              misalign_c;
  logic              flush_c;
  logic [SUM_WD-1:0] tree_sum;
  logic              tree_vld;
  logic [OUT_WD-1:0] sat_c;
  logic              last_c;
  logic [CNT_WD-1:0] line_len_q;
  logic [CNT_WD-1:0] next_idx;

  assign in_ok_c    = start & ~tx_en & (&ch_din_valid);
  assign misalign_c = start & ~tx_en & (|ch_din_valid) & ~(&ch_din_valid);
  assign flush_c    = ~start;

  // log2(NUM_CH) registered levels, each one bit wider than the last
  for (genvar l = 0; l < int'(TREE_LVLS); l++) begin : g_lvl
    localparam int unsigned N_IN = NUM_CH >> l;
    localparam int unsigned W_IN = CH_WD + int'(l);

    logic [(N_IN/2)*(W_IN+1)-1:0] sum;
    logic                         vld;

    if (l == 0) begin : g_first
      dbf_add_level #(.N(N_IN), .W(W_IN)) u_lvl (
        .clk(clk), .rst_n(rst_n), .flush(flush_c),
        .in_valid(in_ok_c), .din(ch_din),
        .dout(sum), .dout_valid(vld)
      );
    end else begin : g_next
      dbf_add_level #(.N(N_IN), .W(W_IN)) u_lvl (
        .clk(clk), .rst_n(rst_n), .flush(flush_c),
        .in_valid(g_lvl[l-1].vld), .din(g_lvl[l-1].sum),
        .dout(sum), .dout_valid(vld)
      );
    end
  end

  assign tree_sum = g_lvl[TREE_LVLS-1].sum;
  assign tree_vld = g_lvl[TREE_LVLS-1].vld;

  // Clamp when the bits above the output sign are not a pure sign extension
  always_comb begin
    sat_c = tree_sum[OUT_WD-1:0];
    if (tree_sum[SUM_WD-1:OUT_WD-1] != {EXT_WD{tree_sum[SUM_WD-1]}}) begin
      sat_c = tree_sum[SUM_WD-1] ? SAT_LO : SAT_HI;
    end
  end

  assign last_c = (line_len_q != '0) && (next_idx == line_len_q - CNT_WD'(1));

  // Line length tracks the input while idle, so it freezes at the start rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_len_q <= '0;
      valid_err  <= 1'b0;
    end else if (!start) begin
      line_len_q <= line_len;
      valid_err  <= 1'b0;
    end else if (misalign_c) begin
      valid_err  <= 1'b1;
    end
  end

  // Output register and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_dout       <= '0;
      bf_dout_valid <= 1'b0;
      sample_cnt    <= '0;
      next_idx      <= '0;
      line_done     <= 1'b0;
    end else if (!start) begin
      bf_dout_valid <= 1'b0;
      sample_cnt    <= '0;
      next_idx      <= '0;
      line_done     <= 1'b0;
    end else begin
      bf_dout_valid <= tree_vld;
      line_done     <= tree_vld & last_c;
      if (tree_vld) begin
        bf_dout    <= sat_c;
        sample_cnt <= next_idx;
        next_idx   <= last_c ? '0 : next_idx + CNT_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_dbf_sum_tree.sv
// Directed self-checking bench for dbf_sum_tree with default parameters.
module tb_dbf_sum_tree;
  import dbf_sum_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    tx_en;
  logic [NUM_CH*CH_WD-1:0] ch_din;
  logic [NUM_CH-1:0]       ch_din_valid;
  logic [CNT_WD-1:0]       line_len;
  logic [OUT_WD-1:0]       bf_dout;
  logic                    bf_dout_valid;
  logic [CNT_WD-1:0]       sample_cnt;
  logic                    line_done;
  logic                    valid_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dbf_sum_tree #(
    .NUM_CH(NUM_CH), .CH_WD(CH_WD), .OUT_WD(OUT_WD), .CNT_WD(CNT_WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_en(tx_en),
    .ch_din(ch_din), .ch_din_valid(ch_din_valid), .line_len(line_len),
    .bf_dout(bf_dout), .bf_dout_valid(bf_dout_valid), .sample_cnt(sample_cnt),
    .line_done(line_done), .valid_err(valid_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [CH_WD-1:0] v);
    for (int k = 0; k < int'(NUM_CH); k++) ch_din[k*CH_WD +: CH_WD] = v;
  endtask

  task automatic drive_alt(input logic [CH_WD-1:0] ev, input logic [CH_WD-1:0] od);
    for (int k = 0; k < int'(NUM_CH); k++) ch_din[k*CH_WD +: CH_WD] = (k % 2 == 0) ? ev : od;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b1; tx_en = 1'b1; ch_din = '1; ch_din_valid = '1; line_len = '1;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    n_total++; if (bf_dout !== '0) $display("FAIL reset_dout: got %0h exp 0", bf_dout); else n_pass++;
    n_total++; if (bf_dout_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", bf_dout_valid); else n_pass++;
    n_total++; if (sample_cnt !== '0) $display("FAIL reset_cnt: got %0d exp 0", sample_cnt); else n_pass++;
    n_total++; if (line_done !== 1'b0) $display("FAIL reset_done: got %0b exp 0", line_done); else n_pass++;
    n_total++; if (valid_err !== 1'b0) $display("FAIL reset_err: got %0b exp 0", valid_err); else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_total++; if (bf_dout_valid !== 1'b0 || bf_dout !== '0)
        $display("FAIL post_reset_out c%0d: got v=%0b d=%0h exp v=0 d=0", c, bf_dout_valid, bf_dout); else n_pass++;
      n_total++; if (valid_err !== 1'b0 || sample_cnt !== '0 || line_done !== 1'b0)
        $display("FAIL post_reset_ctl c%0d: got err=%0b cnt=%0d done=%0b exp 0", c, valid_err, sample_cnt, line_done); else n_pass++;
    end
    start = 1'b0; tx_en = 1'b0; ch_din_valid = '0;
    cyc();
  endtask

  task automatic test_basic();
    start = 1'b0; line_len = CNT_WD'(4); cyc();
    start = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin ch_din_valid = '1; drive_all(CH_WD'(1000)); end
      else ch_din_valid = '0;
      cyc();
      if (c >= 4 && c < 8) begin
        n_total++; if (bf_dout_valid !== 1'b1 || bf_dout !== OUT_WD'(16000))
          $display("FAIL basic_data s%0d: got v=%0b d=%0d exp v=1 d=16000", c-4, bf_dout_valid, $signed(bf_dout)); else n_pass++;
        n_total++; if (sample_cnt !== CNT_WD'(c-4) || line_done !== (c == 7))
          $display("FAIL basic_cnt s%0d: got cnt=%0d done=%0b exp cnt=%0d done=%0b", c-4, sample_cnt, line_done, c-4, c == 7); else n_pass++;
      end else if (c == 8) begin
        n_total++; if (bf_dout_valid !== 1'b0 || line_done !== 1'b0)
          $display("FAIL basic_tail: got v=%0b done=%0b exp 0 0", bf_dout_valid, line_done); else n_pass++;
      end
    end
    start = 1'b0; cyc();
  endtask

  task automatic test_line_wrap();
    line_len = CNT_WD'(3); cyc();
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin ch_din_valid = '1; drive_all(CH_WD'(c+1)); end
      else ch_din_valid = '0;
      cyc();
      if (c >= 4 && c < 9) begin
        n_total++; if (bf_dout_valid !== 1'b1 || bf_dout !== OUT_WD'(16*(c-3)))
          $display("FAIL wrap_data s%0d: got v=%0b d=%0d exp v=1 d=%0d", c-4, bf_dout_valid, $signed(bf_dout), 16*(c-3)); else n_pass++;
        n_total++; if (sample_cnt !== CNT_WD'((c-4) % 3) || line_done !== ((c-4) % 3 == 2))
          $display("FAIL wrap_cnt s%0d: got cnt=%0d done=%0b exp cnt=%0d done=%0b", c-4, sample_cnt, line_done, (c-4) % 3, (c-4) % 3 == 2); else n_pass++;
      end
    end
    start = 1'b0; cyc();
  endtask

  task automatic test_saturation();
    logic [OUT_WD-1:0] exp_d;
    line_len = '0; cyc();
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ch_din_valid = (c < 3) ? '1 : '0;
      if (c == 0) drive_all(32'h7FFF_FFFF);
      else if (c == 1) drive_all(32'h8000_0000);
      else if (c == 2) drive_alt(32'd5, 32'hFFFF_FFFD);
      cyc();
      if (c >= 4 && c < 7) begin
        exp_d = (c == 4) ? SAT_MAX : (c == 5) ? SAT_MIN : OUT_WD'(16);
        n_total++; if (bf_dout_valid !== 1'b1 || bf_dout !== exp_d)
          $display("FAIL sat_data s%0d: got v=%0b d=%0h exp v=1 d=%0h", c-4, bf_dout_valid, bf_dout, exp_d); else n_pass++;
        n_total++; if (sample_cnt !== CNT_WD'(c-4) || line_done !== 1'b0)
          $display("FAIL sat_cnt s%0d: got cnt=%0d done=%0b exp cnt=%0d done=0", c-4, sample_cnt, line_done, c-4); else n_pass++;
      end
    end
    start = 1'b0; cyc();
  endtask

  task automatic test_misalign();
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin ch_din_valid = '1; drive_all(CH_WD'(10)); end
      else if (c == 1) begin ch_din_valid = 16'h00FF; drive_all(CH_WD'(99)); end
      else if (c == 2) begin ch_din_valid = '1; drive_all(CH_WD'(20)); end
      else ch_din_valid = '0;
      cyc();
      if (c == 0) begin
        n_total++; if (valid_err !== 1'b0) $display("FAIL mis_err_pre: got %0b exp 0", valid_err); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if (valid_err !== 1'b1) $display("FAIL mis_err_set: got %0b exp 1", valid_err); else n_pass++;
      end
      if (c == 4 || c == 6) begin
        n_total++; if (bf_dout_valid !== 1'b1 || bf_dout !== OUT_WD'((c == 4) ? 160 : 320) || sample_cnt !== CNT_WD'((c - 4) / 2))
          $display("FAIL mis_neighbour c%0d: got v=%0b d=%0d cnt=%0d exp v=1 d=%0d cnt=%0d", c, bf_dout_valid, $signed(bf_dout), sample_cnt, (c == 4) ? 160 : 320, (c - 4) / 2); else n_pass++;
      end
      if (c == 5 || c == 7) begin
        n_total++; if (bf_dout_valid !== 1'b0) $display("FAIL mis_gap c%0d: got v=%0b exp 0", c, bf_dout_valid); else n_pass++;
      end
    end
    n_total++; if (valid_err !== 1'b1) $display("FAIL mis_err_hold: got %0b exp 1", valid_err); else n_pass++;
    start = 1'b0; cyc();
    n_total++; if (valid_err !== 1'b0 || sample_cnt !== '0)
      $display("FAIL mis_err_clear: got err=%0b cnt=%0d exp 0 0", valid_err, sample_cnt); else n_pass++;
  endtask

  task automatic test_start_fall();
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      start = !(c == 4 || c == 5);
      if (c < 3) begin ch_din_valid = '1; drive_all(CH_WD'(7)); end
      else ch_din_valid = '0;
      cyc();
      if (c >= 4) begin
        n_total++; if (bf_dout_valid !== 1'b0 || sample_cnt !== '0)
          $display("FAIL fall_discard c%0d: got v=%0b cnt=%0d exp v=0 cnt=0", c, bf_dout_valid, sample_cnt); else n_pass++;
      end
    end
    start = 1'b0; cyc();
  endtask

  task automatic test_tx_gap();
    logic exp_v;
    int   exp_cnt;
    cyc();
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin ch_din_valid = '1; drive_all(CH_WD'(100*(c+1))); end
      else ch_din_valid = '0;
      tx_en = (c == 2 || c == 3);
      cyc();
      if (c >= 4) begin
        exp_v   = !(c == 6 || c == 7);
        exp_cnt = (c < 6) ? c - 4 : c - 6;
        n_total++; if (bf_dout_valid !== exp_v)
          $display("FAIL tx_valid c%0d: got %0b exp %0b", c, bf_dout_valid, exp_v); else n_pass++;
        if (exp_v) begin
          n_total++; if (bf_dout !== OUT_WD'(1600*(c-3)) || sample_cnt !== CNT_WD'(exp_cnt))
            $display("FAIL tx_data c%0d: got d=%0d cnt=%0d exp d=%0d cnt=%0d", c, $signed(bf_dout), sample_cnt, 1600*(c-3), exp_cnt); else n_pass++;
        end
      end
    end
    tx_en = 1'b0; start = 1'b0; cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_line_wrap();
    test_saturation();
    test_misalign();
    test_start_fall();
    test_tx_gap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
